// File: rtl/usb_tx_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_encoder
//  Purpose  : Transmit-side USB full-speed line encoder. Accepts packet bytes
//             over a valid/ready handshake, serializes them LSB first, applies
//             bit stuffing and NRZI encoding, drives D+/D- and terminates every
//             packet with an EOP (two bit periods of SE0, then one of J).
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             tx_data_i[7:0]    - packet byte, sent LSB first
//             tx_valid_i        - tx_data_i / tx_last_i valid
//             tx_last_i         - tx_data_i is the final byte of the packet
//             tx_ready_o        - byte holding register empty
//             d_plus_o/d_minus_o- registered USB line outputs
//             tx_busy_o         - first accepted byte through end of EOP J bit
//             tx_done_o         - one-cycle pulse on the final clk of EOP
//             tx_err_o          - one-cycle pulse on holding-register underrun
//  Config   : USB_TX_SYNC_EN    - when defined, a SYNC byte (0x80) is sent
//                                 ahead of the first accepted byte of a packet
//  Revision : 1.0 - initial release
// ============================================================================
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic       d_plus_o,
    output logic       d_minus_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 2);

    // State names describe what is currently on the line, except LOAD,
    // which is the one-clock gap between taking a byte and its first bit.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STUFF = 3'd3;
    localparam logic [2:0] ST_SE0   = 3'd4;
    localparam logic [2:0] ST_EOPJ  = 3'd5;

    logic [2:0]    state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [7:0]    hold_q,      hold_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    shift_q,     shift_d;
    logic          last_q,      last_d;
    logic [2:0]    idx_q,       idx_d;
    logic [2:0]    ones_q,      ones_d;
    logic          level_q,     level_d;   // 1 = J, 0 = K
    logic          dp_q,        dp_d;
    logic          dm_q,        dm_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          err_q,       err_d;

    logic          w_tick;
    logic          w_accept;
    logic          w_emit;
    logic          w_bit;
    logic [2:0]    w_idx_nxt;

    assign w_tick    = (timer_q == TMAX);
    assign w_accept  = tx_valid_i & ~hold_full_q;
    assign w_idx_nxt = idx_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        timer_d     = (state_q == ST_IDLE) ? '0 : (w_tick ? '0 : timer_q + 1'b1);
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        last_d      = last_q;
        idx_d       = idx_q;
        ones_d      = ones_q;
        level_d     = level_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_emit      = 1'b0;
        w_bit       = 1'b0;

        if (w_accept) begin
            hold_d      = tx_data_i;
            hold_last_d = tx_last_i;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    state_d = ST_LOAD;
                    // Preset the timer so the first bit lands on the next edge.
                    timer_d = TMAX;
`ifdef USB_TX_SYNC_EN
                    // SYNC goes out as an ordinary non-final byte; the held
                    // byte follows through the normal byte-boundary reload.
                    shift_d = 8'h80;
                    last_d  = 1'b0;
`else
                    shift_d     = hold_q;
                    last_d      = hold_last_q;
                    hold_full_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (w_tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    w_emit  = 1'b1;
                    w_bit   = shift_q[0];
                end
            end
            ST_DATA, ST_STUFF: begin
                if (w_tick) begin
                    if (ones_q == 3'd6) begin
                        // Six ones just went out: insert the stuffed zero.
                        state_d = ST_STUFF;
                        w_emit  = 1'b1;
                        w_bit   = 1'b0;
                    end else if (idx_q != 3'd7) begin
                        state_d = ST_DATA;
                        idx_d   = w_idx_nxt;
                        w_emit  = 1'b1;
                        w_bit   = shift_q[w_idx_nxt];
                    end else if (last_q) begin
                        state_d = ST_SE0;
                        idx_d   = 3'd0;
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
                    end else if (hold_full_q) begin
                        // Back-to-back reload: bit 0 of the next byte follows
                        // bit 7 with no gap.
                        state_d     = ST_DATA;
                        shift_d     = hold_q;
                        last_d      = hold_last_q;
                        hold_full_d = 1'b0;
                        idx_d       = 3'd0;
                        w_emit      = 1'b1;
                        w_bit       = hold_q[0];
                    end else begin
                        // Underrun: flag it and close the packet cleanly.
                        err_d   = 1'b1;
                        state_d = ST_SE0;
                        idx_d   = 3'd0;
                        dp_d    = 1'b0;
                        dm_d    = 1'b0;
                    end
                end
            end
            ST_SE0: begin
                if (w_tick) begin
                    if (idx_q == 3'd0) begin
                        idx_d = 3'd1;
                    end else begin
                        state_d = ST_EOPJ;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                        level_d = 1'b1;
                        ones_d  = 3'd0;
                    end
                end
            end
            ST_EOPJ: begin
                // Registered pulse lands on the last clk of the J bit.
                done_d = (timer_q == TLAST);
                if (w_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // NRZI: a 0 toggles the line level, a 1 holds it.
        if (w_emit) begin
            if (w_bit) begin
                ones_d = ones_q + 3'd1;
            end else begin
                ones_d  = 3'd0;
                level_d = ~level_q;
            end
            dp_d = w_bit ? level_q : ~level_q;
            dm_d = w_bit ? ~level_q : level_q;
        end

        busy_d = hold_full_d | (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            hold_q      <= 8'h00;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            last_q      <= 1'b0;
            idx_q       <= 3'd0;
            ones_q      <= 3'd0;
            level_q     <= 1'b1;
            dp_q        <= 1'b1;
            dm_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            ones_q      <= ones_d;
            level_q     <= level_d;
            dp_q        <= dp_d;
            dm_q        <= dm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tx_ready_o = ~hold_full_q;
    assign d_plus_o   = dp_q;
    assign d_minus_o  = dm_q;
    assign tx_busy_o  = busy_q;
    assign tx_done_o  = done_q;
    assign tx_err_o   = err_q;

endmodule
`default_nettype wire
